// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Bundle of the fetch stage's handshake signals.
//   - PC side      : imemaddr, rtn_addr (in), pc_advance (out)
//   - I-cache side : iREN (out), ihit, imemload (in)
//   - Control      : flush (redirect), id_ready (decode consumes head)
//   - IF/ID side   : if_valid, if_instr, if_pc, if_npc, halted (out)
//   Modport master is the fetch stage itself; modport slave is the
//   surrounding pipeline (PC, cache, decode, hazard unit).
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic [31:0] imemaddr;
    logic [31:0] rtn_addr;
    logic        iREN;
    logic        ihit;
    logic [31:0] imemload;
    logic        pc_advance;
    logic        flush;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_npc;
    logic        halted;

    modport master (
        input  imemaddr, rtn_addr, ihit, imemload, flush, id_ready,
        output iREN, pc_advance, if_valid, if_instr, if_pc, if_npc, halted
    );

    modport slave (
        output imemaddr, rtn_addr, ihit, imemload, flush, id_ready,
        input  iREN, pc_advance, if_valid, if_instr, if_pc, if_npc, halted
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage directly downstream of the PC. Reads the I-cache
//   at the current PC, captures {instr, pc, pc+4} into a DEPTH-entry circular
//   queue and presents the head to decode as the IF/ID boundary. Generates the
//   PC advance enable and handles redirect flush, decode stall and HALT.
//
//   Parameters
//     DEPTH   : fetch queue entries (>= 1)
//     HALT_OP : instruction word that stops fetching once accepted
//   Ports
//     CLK  : clock, all state updates on the rising edge
//     nRST : asynchronous active-low reset
//     fif  : fetch_stage_if.master (PC, I-cache, control and IF/ID signals)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned DEPTH   = 2,
    parameter logic [31:0] HALT_OP = 32'hFFFF_FFFF
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.master fif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } entry_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];

    logic               iren;
    logic               accept;
    logic               pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;

        // A full queue blocks the read itself, so the PC holds and no fetch
        // is ever dropped for lack of space.
        iren   = (state_q == RUN) && (cnt_q < CNT_W'(DEPTH));
        accept = iren && fif.ihit && !fif.flush;
        pop    = (cnt_q != '0) && fif.id_ready && !fif.flush;

        if (fif.flush) begin
            // Everything queued or arriving this cycle is wrong-path,
            // including a HALT fetched past the taken branch.
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = RUN;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = '{instr: fif.imemload,
                                    pc:    fif.imemaddr,
                                    npc:   fif.rtn_addr};
                wr_ptr_d = ptr_inc(wr_ptr_q);
                if (fif.imemload == HALT_OP) begin
                    state_d = HALTED;
                end
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({accept, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            // NOTE: the queue storage is reset too, because the head fields
            // are visible on the IF/ID outputs and must read 0 out of reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign fif.iREN       = iren;
    assign fif.pc_advance = accept;
    assign fif.if_valid   = (cnt_q != '0);
    // Head fields are shown even when empty; decode ignores them then.
    assign fif.if_instr   = mem_q[rd_ptr_q].instr;
    assign fif.if_pc      = mem_q[rd_ptr_q].pc;
    assign fif.if_npc     = mem_q[rd_ptr_q].npc;
    assign fif.halted     = (state_q == HALTED);

endmodule
